// File: rtl/mul_add_seq.sv
// Sequential radix-2 shift-add multiply-accumulate: product = multiplicand * multiplier + addend.
// Takes a fixed WIDTH cycles per operation and uses the start/busy/ready handshake of the core arithmetic blocks.
module mul_add_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     addend,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow,
    output logic                 busy,
    output logic                 ready
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]           state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     mplr;
    logic [CW-1:0]        count;

    // One partial-product step; the accumulator is wide enough that the sum never wraps.
    always_comb begin
        acc_next = acc;
        if (mplr[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplr     <= '0;
            count    <= '0;
            product  <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= {{WIDTH{1'b0}}, addend};
                        mcand <= {{WIDTH{1'b0}}, multiplicand};
                        mplr  <= multiplier;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    count <= count + CW'(1);
                    // No early exit: latency stays WIDTH cycles regardless of operand values.
                    if (count == LAST) begin
                        product  <= acc_next;
                        overflow <= |acc_next[2*WIDTH-1:WIDTH];
                        ready    <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed and randomized self-checking bench for mul_add_seq at WIDTH=8.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_mul_add_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic [W-1:0]   addend = '0;
    logic [2*W-1:0] product;
    logic           overflow;
    logic           busy;
    logic           ready;

    int total = 0;
    int bad = 0;

    mul_add_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .multiplicand(multiplicand),
        .multiplier(multiplier),
        .addend(addend),
        .product(product),
        .overflow(overflow),
        .busy(busy),
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge; returns just after the accepting edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        step();
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
    endtask

    // Starts an operation and waits (bounded) for ready; lat=-1 on timeout.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                          output int lat, output logic [2*W-1:0] p, output logic ov);
        lat = -1;
        p   = '0;
        ov  = 1'b0;
        start_op(a, b, c);
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ready === 1'b1) begin
                lat = k;
                p   = product;
                ov  = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        step();
        step();
        total++;
        if ({product, overflow, busy, ready} !== {16'd0, 3'b000}) begin
            bad++;
            $display("[TB] FAIL reset_outputs got p=%0d ov=%b busy=%b ready=%b want all zero",
                     product, overflow, busy, ready);
        end
        rst   = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        total++;
        if ({busy, ready} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_start_ignored got busy=%b ready=%b want 0 0", busy, ready);
        end
    endtask

    task automatic test_round_trip();
        start_op(8'd13, 8'd7, 8'd5);
        for (int k = 0; k < W; k++) begin
            total++;
            if ({busy, ready} !== 2'b10) begin
                bad++;
                $display("[TB] FAIL rt_busy_phase k=%0d got busy=%b ready=%b want 1 0", k, busy, ready);
            end
            step();
        end
        total++;
        if ({ready, busy, product, overflow} !== {1'b1, 1'b0, 16'd96, 1'b0}) begin
            bad++;
            $display("[TB] FAIL rt_result got ready=%b busy=%b p=%0d ov=%b want 1 0 96 0",
                     ready, busy, product, overflow);
        end
        step();
        total++;
        if ({ready, product} !== {1'b0, 16'd96}) begin
            bad++;
            $display("[TB] FAIL rt_pulse_hold got ready=%b p=%0d want 0 96", ready, product);
        end
    endtask

    task automatic test_max_and_zero();
        int lat;
        logic [2*W-1:0] p;
        logic ov;
        run_op(8'd255, 8'd255, 8'd255, lat, p, ov);
        total++;
        if (lat != W || p !== 16'hFF00 || ov !== 1'b1) begin
            bad++;
            $display("[TB] FAIL max_ops got lat=%0d p=%0d ov=%b want 8 65280 1", lat, p, ov);
        end
        start_op(8'd0, 8'd200, 8'd0);
        step();
        step();
        total++;
        if (product !== 16'hFF00 || overflow !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hold_while_busy got p=%0d ov=%b want 65280 1", product, overflow);
        end
        lat = -1;
        for (int k = 3; k <= 40; k++) begin
            step();
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat != W || product !== 16'd0 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL zero_ops got lat=%0d p=%0d ov=%b want 8 0 0", lat, product, overflow);
        end
    endtask

    task automatic test_busy_reject();
        int readies = 0;
        int first = -1;
        logic [2*W-1:0] p = '0;
        start_op(8'd10, 8'd10, 8'd0);
        step();
        step();
        step();
        multiplicand = 8'd3;
        multiplier   = 8'd3;
        addend       = 8'd1;
        start        = 1'b1;
        step();
        start        = 1'b0;
        if (ready === 1'b1) begin
            readies++;
        end
        for (int k = 5; k <= 30; k++) begin
            step();
            if (ready === 1'b1) begin
                readies++;
                if (first < 0) begin
                    first = k;
                    p = product;
                end
            end
        end
        total++;
        if (readies != 1 || first != W || p !== 16'd100) begin
            bad++;
            $display("[TB] FAIL busy_reject got readies=%0d lat=%0d p=%0d want 1 8 100", readies, first, p);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        start_op(8'd10, 8'd10, 8'd0);
        for (int k = 1; k < W; k++) begin
            step();
        end
        multiplicand = 8'd2;
        multiplier   = 8'd3;
        addend       = 8'd1;
        start        = 1'b1;
        step();
        total++;
        if ({ready, busy, product} !== {1'b1, 1'b0, 16'd100}) begin
            bad++;
            $display("[TB] FAIL b2b_first got ready=%b busy=%b p=%0d want 1 0 100", ready, busy, product);
        end
        step();
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        addend       = '0;
        total++;
        if ({ready, busy, product} !== {1'b0, 1'b1, 16'd100}) begin
            bad++;
            $display("[TB] FAIL b2b_accept got ready=%b busy=%b p=%0d want 0 1 100", ready, busy, product);
        end
        for (int k = 2; k <= 40; k++) begin
            step();
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
            if (product !== 16'd100) begin
                break;
            end
        end
        total++;
        if (lat != W + 1 || product !== 16'd7 || overflow !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_second got gap=%0d p=%0d ov=%b want 9 7 0", lat, product, overflow);
        end
    endtask

    task automatic test_reset_mid();
        int readies = 0;
        int lat;
        logic [2*W-1:0] p;
        logic ov;
        start_op(8'd200, 8'd200, 8'd0);
        for (int k = 1; k < 5; k++) begin
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({product, overflow, busy, ready} !== {16'd0, 3'b000}) begin
            bad++;
            $display("[TB] FAIL midreset_clear got p=%0d ov=%b busy=%b ready=%b want all zero",
                     product, overflow, busy, ready);
        end
        for (int k = 0; k < 15; k++) begin
            step();
            if (ready === 1'b1 || busy === 1'b1) begin
                readies++;
            end
        end
        total++;
        if (readies != 0) begin
            bad++;
            $display("[TB] FAIL midreset_no_ready got activity=%0d want 0", readies);
        end
        run_op(8'd4, 8'd4, 8'd4, lat, p, ov);
        total++;
        if (lat != W || p !== 16'd20 || ov !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_fresh got lat=%0d p=%0d ov=%b want 8 20 0", lat, p, ov);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2*W-1:0] p;
        logic ov;
        int a, b, c, expv, d, dividend;
        for (int i = 0; i < 500; i++) begin
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            c = $urandom_range(0, 255);
            expv = a * b + c;
            run_op(W'(a), W'(b), W'(c), lat, p, ov);
            total++;
            if (lat != W || int'(p) != expv || ov !== (expv > 255)) begin
                bad++;
                $display("[TB] FAIL rand_mac %0d*%0d+%0d got lat=%0d p=%0d ov=%b want 8 %0d %b",
                         a, b, c, lat, p, ov, expv, expv > 255);
            end
        end
        for (int i = 0; i < 500; i++) begin
            d = $urandom_range(1, 255);
            dividend = $urandom_range(0, 256 * d - 1);
            run_op(W'(dividend / d), W'(d), W'(dividend % d), lat, p, ov);
            total++;
            if (lat != W || int'(p) != dividend) begin
                bad++;
                $display("[TB] FAIL rand_div_inverse q=%0d d=%0d r=%0d got lat=%0d p=%0d want 8 %0d",
                         dividend / d, d, dividend % d, lat, p, dividend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_trip();
        test_max_and_zero();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
